// File: rtl/twp_master.sv
// Two-wire host-side master: serialises write/read frames onto SCL/SDA,
// samples the slave response on reads, and reports done/err to the host.
module twp_master (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   output logic        rdy,
   input  logic        cmd,
   input  logic [7:0]  addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        done,
   output logic        err,
   output logic        SCL,
   inout  wire         SDA
);

   typedef enum logic [2:0] {
      IDLE, SEND, TAR, WAIT_START, RECV, RELEASE, STOP, DONE
   } state_t;

   state_t      state, state_nx;
   logic        phase;        // 0: SCL low half of a bit period, 1: SCL high half
   logic [4:0]  bit_cnt;
   logic [4:0]  to_cnt;
   logic [25:0] sreg;         // outgoing frame, LSB goes out first
   logic        is_wr;
   logic [15:0] rx;
   logic        err_r;
   logic        sda_oe;
   logic        sda_o;
   logic        sda_in;
   logic        last_bit;

   assign sda_in   = SDA;
   assign SDA      = sda_oe ? sda_o : 1'bz;
   assign last_bit = (bit_cnt == (is_wr ? 5'd25 : 5'd9));

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Next-state logic; every bit-period state advances only at the end of its SCL-high half
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:       if (req) state_nx = SEND;
         SEND:       if (phase && last_bit) state_nx = is_wr ? STOP : TAR;
         TAR:        if (phase && bit_cnt == 5'd1) state_nx = WAIT_START;
         WAIT_START: if (phase) begin
                        if (!sda_in)               state_nx = RECV;
                        else if (to_cnt == 5'd15)  state_nx = STOP;
                     end
         RECV:       if (phase && bit_cnt == 5'd15) state_nx = RELEASE;
         RELEASE:    if (phase) state_nx = STOP;
         STOP:       if (phase) state_nx = DONE;
         DONE:       state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end

   // Bus and handshake outputs decoded from state; idle/done park the bus high
   always_comb begin
      rdy    = (state == IDLE);
      done   = (state == DONE);
      err    = err_r;
      SCL    = (state == IDLE || state == DONE) ? 1'b1 : phase;
      sda_oe = (state == IDLE || state == SEND || state == STOP || state == DONE);
      sda_o  = (state == SEND) ? sreg[0] : 1'b1;
   end

   // Datapath: phase, counters, shift registers, read result and error flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase   <= 1'b0;
         bit_cnt <= '0;
         to_cnt  <= '0;
         sreg    <= '0;
         is_wr   <= 1'b0;
         rx      <= '0;
         rdata   <= '0;
         err_r   <= 1'b0;
      end else begin
         if (state == IDLE || state == DONE) phase <= 1'b0;
         else                                phase <= ~phase;

         if (state != state_nx)  bit_cnt <= '0;
         else if (phase)         bit_cnt <= bit_cnt + 5'd1;

         if (state == IDLE && req) begin
            sreg   <= {wdata, addr, cmd, 1'b0};
            is_wr  <= cmd;
            err_r  <= 1'b0;
            to_cnt <= '0;
         end

         if (state == SEND && phase)
            sreg <= {1'b0, sreg[25:1]};

         if (state == WAIT_START && phase && sda_in) begin
            if (to_cnt == 5'd15) err_r  <= 1'b1;
            else                 to_cnt <= to_cnt + 5'd1;
         end

         if (state == RECV && phase) begin
            rx <= {sda_in, rx[15:1]};
            if (bit_cnt == 5'd15) rdata <= {sda_in, rx[15:1]};
         end
      end
   end

endmodule

// File: doc/twp_master.md
TWP_MASTER -- requirements
Module: twp_master

Interface
REQ-001 SHALL have a single clock and an asynchronous active-low reset: clk  input  1  system clock (all logic on rising edge).
REQ-002 SHALL have reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have req  input  1  transaction request from host.
REQ-004 SHALL have rdy  output  1  master idle, can accept req.
REQ-005 SHALL have cmd  input  1  1 = write, 0 = read.
REQ-006 SHALL have addr  input  8  register address.
REQ-007 SHALL have wdata  input  16  write data.
REQ-008 SHALL have rdata  output  16  read data; valid when done=1 and err=0 for a read.
REQ-009 SHALL have done  output  1  one-cycle completion pulse.
REQ-010 SHALL have err  output  1  read timeout flag, valid with done.
REQ-011 SHALL have SCL  output  1  two-wire clock to slave.
REQ-012 SHALL have SDA  inout  1  two-wire data; released = high-Z, bench/board pull-up reads 1.

Function
REQ-013 SHALL send each bit period as 2 clk cycles: SCL=0 then SCL=1; the master SHALL change SDA only in the SCL=0 cycle; the master and slave SHALL sample SDA in the SCL=1 cycle.
REQ-014 SHALL hold SCL=1 and drive SDA=1 while idle.
REQ-015 SHALL accept a request on the rising edge where req=1 and rdy=1: latch cmd/addr/wdata; rdy=0 from the next cycle; req SHALL be ignored while rdy=0.
REQ-016 SHALL send the write frame as start 0, cmd 1, addr[0..7], wdata[0..15] (LSB first), i.e. 26 bits.
REQ-017 SHALL follow the write frame with a 1-bit-period stop (SDA=1).
REQ-018 SHALL send the read frame as start 0, cmd 0, addr[0..7] (10 bits), followed by a turnaround (TAR) of 2 bit periods with SDA released and SCL toggling.
REQ-019 SHALL, after TAR, sample SDA each bit period in state WAIT_START; the first sampled 0 is the slave start bit.
REQ-020 SHALL then sample 16 data bits into rdata[0..15], LSB first.
REQ-021 SHALL then release for 1 bit period (slave release), then drive a 1-bit-period stop with SDA=1.
REQ-022 SHALL time out a read when no start bit is seen within 16 bit periods in WAIT_START: go to STOP, err=1 with done, rdata unchanged.
REQ-023 SHALL use states IDLE, SEND, TAR, WAIT_START, RECV, RELEASE, STOP, DONE.
REQ-024 SHALL take these transitions: IDLE->SEND on acceptance; SEND->STOP (write) or TAR (read) after the last bit; TAR->WAIT_START; WAIT_START->RECV on start bit or STOP on timeout; RECV->RELEASE after 16 bits; RELEASE->STOP; STOP->DONE; DONE->IDLE.
REQ-025 SHALL pulse done in the DONE cycle; rdy=1 from the following cycle, so back-to-back requests gain no overlap.
REQ-026 SHALL give write latency: done asserted on the 55th rising edge after the accepting edge (26x2 + 2 stop + 1).
REQ-027 SHALL hold rdata until the next successful read completes; writes SHALL NOT alter rdata.
REQ-028 SHALL keep the bit counter 5 bits wide and the timeout counter 5 bits wide; neither SHALL wrap inside a frame.

Reset
REQ-029 SHALL, with reset_n=0, force immediately: state IDLE, SCL=1, SDA driven 1, rdy=1, done=0, err=0, rdata=16'h0000, counters 0.
REQ-030 SHALL, on reset mid-frame, abort the frame with no done pulse; the first frame after release SHALL be complete and correct.

Verification
REQ-031 SHALL pass this scenario: write cmd=1 addr=8'h3C wdata=16'hA5F0 -> SDA bit sequence 0,1,0,0,1,1,1,1,0,0, then 0,0,0,0,1,1,1,1,1,0,1,0,0,1,0,1; done at edge 55; err=0.
REQ-032 SHALL pass this scenario: read addr=8'h01, slave model drives start 0 in the 3rd WAIT_START period, then 16'h1234 LSB first -> done with rdata=16'h1234, err=0.
REQ-033 SHALL pass this scenario: read with slave silent -> after 16 WAIT_START periods: done=1, err=1, rdata retains previous value.
REQ-034 SHALL pass this scenario: req held high continuously for two writes -> exactly two frames, separated by at least the stop bit plus 1 idle cycle; a req change while busy is ignored.
REQ-035 SHALL pass this scenario: reset_n pulsed low at bit 12 of a write -> SCL=1 and SDA=1 immediately, no done; the following read of 8'hFF completes normally.
REQ-036 SHALL pass this scenario: SDA checked every cycle -> never driven by the master during TAR, WAIT_START, RECV or RELEASE.
